stage_5_output_buffer: RTL

- Sits directly downstream of the carry-propagation stage (stage 4).
- Each cycle it accepts 0–5 finished bitstream bytes in parallel, plus a byte-count flag and an end-of-stream flag.
- Stores the bytes in order in a circular register FIFO.
- Emits them one byte per cycle to the external consumer over a valid/ready handshake, then signals stream completion.

---
 rtl/stage_5_output_buffer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/stage_5_output_buffer.sv
// Output buffer after carry propagation: up to five bytes per cycle go into a
// circular register FIFO and leave one byte per cycle over valid/ready.

// Per-lane write slot: lane k of an accepted group lands at base + k.
module stage_5_lane #(
  parameter int AW   = 5,
  parameter int LANE = 0
) (
  input  logic [AW-1:0] base_i,
  input  logic [2:0]    n_i,
  input  logic          grp_en_i,
  output logic [AW-1:0] addr_o,
  output logic          we_o
);
  assign addr_o = base_i + AW'(LANE);
  assign we_o   = grp_en_i && (n_i > 3'(LANE));
endmodule

module stage_5_output_buffer #(
  parameter int S5_BITSTREAM_WIDTH  = 8,
  parameter int S5_FIFO_DEPTH       = 32,
  parameter int S5_ADDR_WIDTH       = 5,
  parameter int S5_ALMOST_FULL_FREE = 8
) (
  input  logic                          s5_clk,
  input  logic                          s5_reset,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_bit_1,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_bit_2,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_bit_3,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_bit_4,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_bit_5,
  input  logic [2:0]                    in_flag,
  input  logic                          in_flag_last,
  input  logic                          in_ready,
  output logic [S5_BITSTREAM_WIDTH-1:0] out_byte,
  output logic                          out_valid,
  output logic                          out_last,
  output logic                          out_done,
  output logic                          out_almost_full,
  output logic                          out_overflow,
  output logic [S5_ADDR_WIDTH:0]        out_count
);
  localparam int NUM_LANES = 5;
  localparam int W         = S5_BITSTREAM_WIDTH;
  localparam int AW        = S5_ADDR_WIDTH;
  localparam int CW        = S5_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAST_PENDING,
    S_DONE
  } eos_t;

  logic [W-1:0] mem [S5_FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  eos_t          state_q, state_d;

  logic [NUM_LANES-1:0][W-1:0]  lane_data;
  logic [NUM_LANES-1:0][AW-1:0] lane_addr;
  logic [NUM_LANES-1:0]         lane_we;

  logic [2:0]    n;
  logic [CW-1:0] free;
  logic          wr_acc;
  logic          wr_en;
  logic          pop;

  assign lane_data[0] = in_bit_1;
  assign lane_data[1] = in_bit_2;
  assign lane_data[2] = in_bit_3;
  assign lane_data[3] = in_bit_4;
  assign lane_data[4] = in_bit_5;

  // Out-of-range flag codes behave as an empty group, not an error.
  assign n = (in_flag <= 3'd5) ? in_flag : 3'd0;

  // Space is judged on the registered count, ignoring any same-cycle pop.
  assign free   = CW'(S5_FIFO_DEPTH) - count_q;
  assign wr_acc = (CW'(n) <= free);
  assign wr_en  = wr_acc && (n != 3'd0);

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && in_ready;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    stage_5_lane #(.AW(AW), .LANE(i)) u_lane (
      .base_i   (wr_ptr_q),
      .n_i      (n),
      .grp_en_i (wr_en),
      .addr_o   (lane_addr[i]),
      .we_o     (lane_we[i])
    );
  end

  always_ff @(posedge s5_clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_we[i]) mem[lane_addr[i]] <= lane_data[i];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + (wr_en ? AW'(n) : '0);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (wr_en ? CW'(n) : '0) - CW'(pop);
    ovf_d    = ovf_q | ~wr_acc;
  end

  // End-of-stream tracking; an already-empty FIFO still finishes through
  // one LAST_PENDING cycle so out_done always follows the flag.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE:         if (in_flag_last) state_d = S_LAST_PENDING;
      S_LAST_PENDING: if (count_d == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                      end
      S_DONE:         if (!in_flag_last) state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge s5_clk or negedge s5_reset) begin
    if (!s5_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      state_q  <= S_IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      state_q  <= state_d;
    end
  end

  assign out_byte        = out_valid ? mem[rd_ptr_q] : '0;
  assign out_last        = (state_q == S_LAST_PENDING) && (count_q == CW'(1));
  assign out_done        = done_q;
  assign out_almost_full = (free <= CW'(S5_ALMOST_FULL_FREE));
  assign out_overflow    = ovf_q;
  assign out_count       = count_q;

endmodule
